// File: rtl/chacha_pkg.sv
// Shared types, sigma constants and initial-state builder for the ChaCha20 block sequencer.
package chacha_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [3:0][3:0] mat_t;

    localparam word_t SIGMA0 = 32'h61707865;
    localparam word_t SIGMA1 = 32'h3320646e;
    localparam word_t SIGMA2 = 32'h79622d32;
    localparam word_t SIGMA3 = 32'h6b206574;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, STREAM, DONE} seq_state_t;

    // [row][col] layout: sigma, key 0-3, key 4-7, {ctr, nonce0..2}
    function automatic mat_t build_state(input logic [255:0] key, input logic [95:0] nonce,
                                         input word_t ctr);
        mat_t m;
        m[0][0] = SIGMA0;
        m[0][1] = SIGMA1;
        m[0][2] = SIGMA2;
        m[0][3] = SIGMA3;
        for (int c = 0; c < 4; c++) begin
            m[1][c] = key[32*c +: 32];
            m[2][c] = key[32*(c+4) +: 32];
        end
        m[3][0] = ctr;
        m[3][1] = nonce[31:0];
        m[3][2] = nonce[63:32];
        m[3][3] = nonce[95:64];
        return m;
    endfunction

endpackage

// File: rtl/chacha_ks_serializer.sv
// Holds one captured keystream block and emits its 16 words row-major over valid/ready.
module chacha_ks_serializer
    import chacha_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load_i,
    input  mat_t  matrix_i,
    input  logic  final_blk_i,
    input  logic  ready_i,
    output word_t word_o,
    output logic  valid_o,
    output logic  last_o,
    output logic  drained_o
);

    mat_t       mat_q;
    logic [3:0] idx_q;
    logic       valid_q;
    logic       fin_q;
    logic       accept;

    assign accept = valid_q && ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            fin_q   <= 1'b0;
        end else if (load_i) begin
            mat_q   <= matrix_i;
            idx_q   <= '0;
            valid_q <= 1'b1;
            fin_q   <= final_blk_i;
        end else if (accept) begin
            idx_q   <= idx_q + 4'd1;
            valid_q <= (idx_q != 4'hF);
        end
    end

    // Word and last derive only from registers, so they hold while stalled
    assign word_o    = mat_q[idx_q[3:2]][idx_q[1:0]];
    assign valid_o   = valid_q;
    assign last_o    = valid_q && fin_q && (idx_q == 4'hF);
    assign drained_o = accept && (idx_q == 4'hF);

endmodule

// File: rtl/chacha_block_sequencer.sv
// Drives the ChaCha20 block core for NUM consecutive counters and streams the keystream.
// Optional wait-for-blockready timeout enabled by defining CHACHA_SEQ_TIMEOUT_EN.
module chacha_block_sequencer
    import chacha_pkg::*;
#(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [255:0]        key,
    input  logic [95:0]         nonce,
    input  logic [31:0]         init_counter,
    input  logic [15:0]         num_blocks,
    output word_t [3:0][3:0]    chachamatrixIN,
    output logic                setRounds,
    input  word_t [3:0][3:0]    chachamatrixOUT,
    input  logic                blockready,
    output logic [31:0]         ks_word,
    output logic                ks_valid,
    input  logic                ks_ready,
    output logic                ks_last,
    output logic                busy,
    output logic                done,
    output logic                err
);

    seq_state_t  state_q;
    mat_t        min_q;
    word_t       ctr_q;
    logic [15:0] rem_q;
    logic [7:0]  setup_q;
    logic        br_q;
    logic        setrounds_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
`ifdef CHACHA_SEQ_TIMEOUT_EN
    logic [31:0] wait_q;
`endif

    logic br_edge;
    logic capture;
    logic drained;

    // Only a fresh 0->1 transition counts; a level left high from before RUN is ignored
    assign br_edge = blockready && !br_q;
    assign capture = (state_q == RUN) && br_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            min_q       <= '0;
            ctr_q       <= '0;
            rem_q       <= '0;
            setup_q     <= '0;
            br_q        <= 1'b0;
            setrounds_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef CHACHA_SEQ_TIMEOUT_EN
            wait_q      <= '0;
`endif
        end else begin
            br_q   <= blockready;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        min_q   <= build_state(key, nonce, init_counter);
                        ctr_q   <= init_counter;
                        rem_q   <= num_blocks;
                        setup_q <= '0;
                        if (num_blocks == 16'd0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= LOAD;
                            setrounds_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (setup_q == 8'(SETUP_CYCLES - 1)) begin
                        setrounds_q <= 1'b0;
                        state_q     <= RUN;
`ifdef CHACHA_SEQ_TIMEOUT_EN
                        wait_q      <= '0;
`endif
                    end else begin
                        setup_q <= setup_q + 8'd1;
                    end
                end
                RUN: begin
                    if (br_edge) begin
                        state_q <= STREAM;
`ifdef CHACHA_SEQ_TIMEOUT_EN
                    end else if (wait_q == 32'(TIMEOUT_CYCLES - 1)) begin
                        err_q       <= 1'b1;
                        busy_q      <= 1'b0;
                        setrounds_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        wait_q <= wait_q + 32'd1;
`endif
                    end
                end
                STREAM: begin
                    if (drained) begin
                        if (rem_q == 16'd1) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (ctr_q == 32'hFFFF_FFFF) begin
                            // Next block would need a wrapped counter: abort instead
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            ctr_q       <= ctr_q + 32'd1;
                            min_q[3][0] <= ctr_q + 32'd1;
                            rem_q       <= rem_q - 16'd1;
                            setup_q     <= '0;
                            setrounds_q <= 1'b1;
                            state_q     <= LOAD;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    chacha_ks_serializer u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (capture),
        .matrix_i   (chachamatrixOUT),
        .final_blk_i(rem_q == 16'd1),
        .ready_i    (ks_ready),
        .word_o     (ks_word),
        .valid_o    (ks_valid),
        .last_o     (ks_last),
        .drained_o  (drained)
    );

    assign chachamatrixIN = min_q;
    assign setRounds      = setrounds_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_chacha_block_sequencer.sv
// Directed bench for chacha_block_sequencer with a behavioural block-core model.
module tb_chacha_block_sequencer;
    import chacha_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  init_counter;
    logic [15:0]  num_blocks;
    mat_t         chachamatrixIN;
    logic         setRounds;
    mat_t         chachamatrixOUT;
    logic         blockready;
    logic [31:0]  ks_word;
    logic         ks_valid;
    logic         ks_ready;
    logic         ks_last;
    logic         busy;
    logic         done;
    logic         err;

    int errors = 0;
    int checks = 0;

    chacha_block_sequencer #(.SETUP_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .nonce(nonce),
        .init_counter(init_counter), .num_blocks(num_blocks),
        .chachamatrixIN(chachamatrixIN), .setRounds(setRounds),
        .chachamatrixOUT(chachamatrixOUT), .blockready(blockready),
        .ks_word(ks_word), .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_last(ks_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    word_t rfc_ks [16] = '{
        32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
        32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
        32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
        32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

    // Core model: rfc_mode returns the RFC block, otherwise input ^ (A5A50000 | index)
    bit   core_en   = 1'b1;
    bit   rfc_mode  = 1'b0;
    logic sr_prev;
    int   core_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_prev         <= 1'b0;
            core_cnt        <= 0;
            blockready      <= 1'b0;
            chachamatrixOUT <= '0;
        end else begin
            sr_prev    <= setRounds;
            blockready <= (core_cnt == 1);
            if (sr_prev && !setRounds && core_en) core_cnt <= 5;
            else if (core_cnt != 0) begin
                core_cnt <= core_cnt - 1;
                if (core_cnt == 1)
                    for (int r = 0; r < 4; r++)
                        for (int c = 0; c < 4; c++)
                            chachamatrixOUT[r][c] <= rfc_mode ? rfc_ks[r*4+c]
                                : (chachamatrixIN[r][c] ^ (32'hA5A50000 | 32'(r*4+c)));
            end
        end
    end

    int    n_loads = 0;
    int    n_done  = 0;
    int    n_valid = 0;
    word_t load_log [64];

    always @(posedge clk) begin
        if (setRounds && !sr_prev) begin
            load_log[n_loads & 63] <= chachamatrixIN[3][0];
            n_loads <= n_loads + 1;
        end
        if (done) n_done <= n_done + 1;
        if (ks_valid) n_valid <= n_valid + 1;
    end

    word_t cap_w [64];

    function automatic word_t exp_in(input logic [255:0] k, input logic [95:0] n,
                                     input word_t c, input int i);
        if (i == 0) return 32'h61707865;
        if (i == 1) return 32'h3320646e;
        if (i == 2) return 32'h79622d32;
        if (i == 3) return 32'h6b206574;
        if (i < 12) return k[32*(i-4) +: 32];
        if (i == 12) return c;
        return n[32*(i-13) +: 32];
    endfunction

    function automatic word_t exp_ks(input logic [255:0] k, input logic [95:0] n,
                                     input word_t c, input int i);
        return exp_in(k, n, c, i) ^ (32'hA5A50000 | 32'(i));
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [255:0] k, input logic [95:0] n,
                               input word_t c, input logic [15:0] nb);
        @(negedge clk);
        key = k; nonce = n; init_counter = c; num_blocks = nb; start = 1'b1;
        @(negedge clk);
        start = 1'b0; key = ~k; nonce = ~n; init_counter = ~c; num_blocks = 16'hFFFF;
    endtask

    task automatic collect(input int n, input bit bp, output int got, output int lasts,
                           output int last_idx, output int unstable);
        int          budget;
        bit          stalled;
        word_t       pw;
        logic        pl;
        logic [15:0] pat;
        got = 0; lasts = 0; last_idx = -1; unstable = 0;
        budget = 0; stalled = 1'b0; pw = '0; pl = 1'b0; pat = 16'hB2E5;
        while (got < n && budget < 3000) begin
            @(negedge clk);
            budget++;
            ks_ready = bp ? pat[budget % 16] : 1'b1;
            if (ks_valid) begin
                if (stalled && (ks_word !== pw || ks_last !== pl)) unstable++;
                if (ks_ready) begin
                    cap_w[got] = ks_word;
                    if (ks_last) begin lasts++; last_idx = got; end
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1; pw = ks_word; pl = ks_last;
                end
            end else stalled = 1'b0;
        end
        @(posedge clk);
        #1 ks_ready = 1'b0;
    endtask

    logic [255:0] kt;
    logic [95:0]  nt;

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; ks_ready = 1'b0;
        key = '0; nonce = '0; init_counter = '0; num_blocks = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({setRounds, ks_valid, ks_last, busy, done, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000", {setRounds, ks_valid, ks_last, busy, done, err});
        end
        checks++;
        if (chachamatrixIN !== '0 || ks_word !== '0) begin
            errors++;
            $display("FAIL reset_data: matrix %h word %h want 0", chachamatrixIN, ks_word);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rfc();
        int ok, w, got, lasts, li, uns, d0, bad;
        logic [255:0] k;
        for (int i = 0; i < 32; i++) k[8*i +: 8] = 8'(i);
        rfc_mode = 1'b1;
        d0 = n_done;
        pulse_start(k, {32'h00000000, 32'h4a000000, 32'h09000000}, 32'd1, 16'd1);
        ok = 0;
        for (int t = 0; t < 50 && ok == 0; t++) if (setRounds) ok = 1; else @(negedge clk);
        checks++;
        if (ok != 1) begin errors++; $display("FAIL rfc_setrounds: got %0d want 1", ok); end
        checks++;
        if (chachamatrixIN[3] !== {32'h00000000, 32'h4a000000, 32'h09000000, 32'h00000001}) begin
            errors++; $display("FAIL rfc_row3: got %h want 00000000_4a000000_09000000_00000001", chachamatrixIN[3]);
        end
        checks++;
        if (chachamatrixIN[0][0] !== 32'h61707865 || chachamatrixIN[1][0] !== 32'h03020100 ||
            chachamatrixIN[2][3] !== 32'h1f1e1d1c) begin
            errors++; $display("FAIL rfc_rows012: got %h %h %h", chachamatrixIN[0][0],
                               chachamatrixIN[1][0], chachamatrixIN[2][3]);
        end
        w = 0;
        while (setRounds && w < 20) begin w++; @(negedge clk); end
        checks++;
        if (w != 2) begin errors++; $display("FAIL rfc_setup_width: got %0d want 2", w); end
        collect(16, 1'b0, got, lasts, li, uns);
        bad = 0;
        for (int i = 0; i < 16; i++) if (cap_w[i] !== rfc_ks[i]) bad++;
        checks++;
        if (got != 16 || cap_w[0] !== 32'he4e7f110 || cap_w[3] !== 32'hc47120a3 || bad != 0) begin
            errors++; $display("FAIL rfc_words: got %0d words, w0 %h w3 %h, %0d bad", got, cap_w[0], cap_w[3], bad);
        end
        checks++;
        if (lasts != 1 || li != 15) begin
            errors++; $display("FAIL rfc_last: got %0d at %0d want 1 at 15", lasts, li);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (n_done - d0 != 1 || busy !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL rfc_done: done %0d busy %b err %b want 1 0 0", n_done - d0, busy, err);
        end
        rfc_mode = 1'b0;
    endtask

    task automatic run_multi(input string nm, input bit bp, input int nb);
        int got, lasts, li, uns, l0, d0, bad;
        l0 = n_loads; d0 = n_done;
        pulse_start(kt, nt, 32'd7, 16'(nb));
        collect(16*nb, bp, got, lasts, li, uns);
        bad = 0;
        for (int b = 0; b < nb; b++)
            for (int i = 0; i < 16; i++)
                if (cap_w[16*b+i] !== exp_ks(kt, nt, 32'(7+b), i)) bad++;
        checks++;
        if (got != 16*nb || bad != 0) begin
            errors++; $display("FAIL %s_words: got %0d words %0d bad, want %0d words 0 bad", nm, got, bad, 16*nb);
        end
        checks++;
        if (lasts != 1 || li != 16*nb-1) begin
            errors++; $display("FAIL %s_last: got %0d at %0d want 1 at %0d", nm, lasts, li, 16*nb-1);
        end
        checks++;
        if (uns != 0) begin errors++; $display("FAIL %s_stall_hold: got %0d changes want 0", nm, uns); end
        repeat (4) @(negedge clk);
        checks++;
        if (n_loads - l0 != nb || load_log[l0 & 63] !== 32'd7 || load_log[(l0+nb-1) & 63] !== 32'(7+nb-1)) begin
            errors++; $display("FAIL %s_ctrs: loads %0d first %h final %h", nm, n_loads - l0,
                               load_log[l0 & 63], load_log[(l0+nb-1) & 63]);
        end
        checks++;
        if (n_done - d0 != 1) begin errors++; $display("FAIL %s_done: got %0d want 1", nm, n_done - d0); end
    endtask

    task automatic test_multi();
        run_multi("multi", 1'b0, 3);
        checks++;
        if (load_log[(n_loads-2) & 63] !== 32'd8) begin
            errors++; $display("FAIL multi_mid_ctr: got %h want 00000008", load_log[(n_loads-2) & 63]);
        end
    endtask

    task automatic test_backpressure();
        run_multi("bp", 1'b1, 2);
    endtask

    task automatic test_overflow();
        int got, lasts, li, uns, l0, d0, bad;
        l0 = n_loads; d0 = n_done;
        pulse_start(kt, nt, 32'hFFFFFFFE, 16'd3);
        collect(32, 1'b0, got, lasts, li, uns);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (cap_w[i] !== exp_ks(kt, nt, 32'hFFFFFFFE, i)) bad++;
            if (cap_w[16+i] !== exp_ks(kt, nt, 32'hFFFFFFFF, i)) bad++;
        end
        checks++;
        if (got != 32 || bad != 0 || lasts != 0) begin
            errors++; $display("FAIL ovf_words: got %0d words %0d bad %0d last, want 32 0 0", got, bad, lasts);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL ovf_err: err %b busy %b want 1 0", err, busy);
        end
        checks++;
        if (n_loads - l0 != 2 || n_done - d0 != 0) begin
            errors++; $display("FAIL ovf_loads: loads %0d done %0d want 2 0", n_loads - l0, n_done - d0);
        end
    endtask

    task automatic test_zero();
        int l0;
        l0 = n_loads;
        pulse_start(kt, nt, 32'd5, 16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL zero_done: done %b busy %b err %b want 1 1 0", done, busy, err);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || n_loads != l0) begin
            errors++; $display("FAIL zero_after: done %b busy %b loads %0d want 0 0 0", done, busy, n_loads - l0);
        end
    endtask

    task automatic test_reset_mid();
        int got, lasts, li, uns;
        pulse_start(kt, nt, 32'd3, 16'd1);
        collect(5, 1'b0, got, lasts, li, uns);
        @(negedge clk);
        checks++;
        if (ks_valid !== 1'b1 || ks_word !== exp_ks(kt, nt, 32'd3, 5)) begin
            errors++; $display("FAIL mid_word5: valid %b word %h want 1 %h", ks_valid, ks_word, exp_ks(kt, nt, 32'd3, 5));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({setRounds, ks_valid, ks_last, busy, done, err} !== 6'b0 || ks_word !== '0 || chachamatrixIN !== '0) begin
            errors++; $display("FAIL mid_reset: ctrl %b word %h want 000000 0",
                               {setRounds, ks_valid, ks_last, busy, done, err}, ks_word);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start(kt, nt, 32'd3, 16'd1);
        collect(1, 1'b0, got, lasts, li, uns);
        checks++;
        if (got != 1 || cap_w[0] !== exp_ks(kt, nt, 32'd3, 0)) begin
            errors++; $display("FAIL mid_restart: got %0d word %h want 1 %h", got, cap_w[0], exp_ks(kt, nt, 32'd3, 0));
        end
        apply_reset();
    endtask

`ifdef CHACHA_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int ok, n, v0;
        core_en = 1'b0;
        v0 = n_valid;
        pulse_start(kt, nt, 32'd1, 16'd1);
        ok = 0;
        for (int t = 0; t < 50 && ok == 0; t++) if (!setRounds) ok = 1; else @(negedge clk);
        n = 0;
        while (err !== 1'b1 && n < 100) begin n++; @(negedge clk); end
        checks++;
        if (ok != 1 || n != 16) begin errors++; $display("FAIL tmo_cycles: got %0d want 16", n); end
        checks++;
        if (busy !== 1'b0 || setRounds !== 1'b0) begin
            errors++; $display("FAIL tmo_idle: busy %b setRounds %b want 0 0", busy, setRounds);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (n_valid != v0) begin errors++; $display("FAIL tmo_valid: got %0d valid cycles want 0", n_valid - v0); end
        core_en = 1'b1;
    endtask
`endif

    initial begin
        for (int i = 0; i < 8; i++) kt[32*i +: 32] = 32'h1111_1111 * (i + 1);
        nt = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
        test_reset();
        test_rfc();
        test_multi();
        test_backpressure();
        test_overflow();
        test_zero();
        test_reset_mid();
`ifdef CHACHA_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
